alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 128 ++++++++++++
 tb/tb_alu_issue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: decodes MIPS ALU instructions, issues them to an external ALU and writes results back
module alu_issue (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [4:0]  out_rd,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic live;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sh;
  logic [31:0] sext, zext;
  logic legal, acc;
  logic [3:0] d_ctrl;
  logic [31:0] d_op1, d_op2;
  logic [4:0] d_dest;
  assign op = in_instr[31:26];
  assign rs = in_instr[25:21];
  assign rt = in_instr[20:16];
  assign rd = in_instr[15:11];
  assign sh = in_instr[10:6];
  assign fn = in_instr[5:0];
  assign sext = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zext = {16'd0, in_instr[15:0]};
  // live holds in_ready low until the first edge after reset release
  assign in_ready = live & (state == IDLE);
  assign acc = in_valid & in_ready;
  assign out_valid = state == RESP;
  // decode the offered instruction into ALU control, operands and destination
  always_comb begin
    legal = 1'b1;
    d_ctrl = 4'd0;
    d_op1 = rf[rs];
    d_op2 = rf[rt];
    d_dest = rt;
    if (op == 6'h00) begin
      d_dest = rd;
      case (fn)
        6'h00, 6'h02, 6'h03: begin
          d_ctrl = fn == 6'h00 ? 4'd0 : fn == 6'h02 ? 4'd1 : 4'd2;
          d_op1 = rf[rt];
          d_op2 = {27'd0, sh};
        end
        6'h20: d_ctrl = 4'd3;
        6'h22: d_ctrl = 4'd4;
        6'h24: d_ctrl = 4'd5;
        6'h25: d_ctrl = 4'd6;
        6'h26: d_ctrl = 4'd7;
        6'h27: d_ctrl = 4'd8;
        6'h2A: d_ctrl = 4'd9;
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08: begin d_ctrl = 4'd3; d_op2 = sext; end
        6'h0A: begin d_ctrl = 4'd9; d_op2 = sext; end
        6'h0C: begin d_ctrl = 4'd5; d_op2 = zext; end
        6'h0D: begin d_ctrl = 4'd6; d_op2 = zext; end
        6'h0E: begin d_ctrl = 4'd7; d_op2 = zext; end
        6'h0F: begin d_ctrl = 4'd10; d_op1 = zext; d_op2 = '0; end
        default: legal = 1'b0;
      endcase
    end
  end
  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: illegal accepts leave the FSM in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = acc && legal ? EXEC : IDLE;
      EXEC: state_nx = RESP;
      RESP: state_nx = out_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // issue registers, result capture and error pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live <= 1'b0;
      err <= 1'b0;
      alu_ctrl <= '0;
      alu_op1 <= '0;
      alu_op2 <= '0;
      out_rd <= '0;
      out_result <= '0;
      out_zero <= 1'b0;
    end else begin
      live <= 1'b1;
      err <= acc & ~legal;
      if (acc && legal) begin
        alu_ctrl <= d_ctrl;
        alu_op1 <= d_op1;
        alu_op2 <= d_op2;
        out_rd <= d_dest;
      end
      if (state == EXEC) begin
        out_result <= alu_result;
        out_zero <= alu_zero;
      end
    end
  end
  // register file writeback on result handshake; r0 is never written
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (out_valid && out_ready && out_rd != 5'd0) begin
      rf[out_rd] <= out_result;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue with a behavioural ALU
module tb_alu_issue;
  logic clock = 1'b0;
  logic reset_n, in_valid, in_ready, alu_zero, out_valid, out_ready, out_zero, err;
  logic [31:0] in_instr, alu_op1, alu_op2, alu_result, out_result;
  logic [3:0] alu_ctrl;
  logic [4:0] out_rd;
  int errors = 0;
  int checks = 0;

  alu_issue dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_rd(out_rd), .err(err)
  );

  always #5 clock = ~clock;

  // reference ALU; SLT compares unsigned
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'd0: alu_result = alu_op1 << alu_op2[4:0];
      4'd1: alu_result = alu_op1 >> alu_op2[4:0];
      4'd2: alu_result = 32'($signed(alu_op1) >>> alu_op2[4:0]);
      4'd3: alu_result = alu_op1 + alu_op2;
      4'd4: alu_result = alu_op1 - alu_op2;
      4'd5: alu_result = alu_op1 & alu_op2;
      4'd6: alu_result = alu_op1 | alu_op2;
      4'd7: alu_result = alu_op1 ^ alu_op2;
      4'd8: alu_result = ~(alu_op1 | alu_op2);
      4'd9: alu_result = {31'd0, alu_op1 < alu_op2};
      4'd10: alu_result = alu_op1 << 16;
      default: alu_result = '0;
    endcase
    alu_zero = alu_result == 32'd0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic [3:0] c,
                     input logic [31:0] r, input logic z, input logic [4:0] d);
    @(negedge clock);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clock);
    in_valid = 1'b0;
    chk({tag, ".ctrl"}, 32'(alu_ctrl), 32'(c));
    chk({tag, ".exec_valid"}, 32'(out_valid), 32'h0);
    @(negedge clock);
    chk({tag, ".valid"}, 32'(out_valid), 32'h1);
    chk({tag, ".result"}, out_result, r);
    chk({tag, ".zero"}, 32'(out_zero), 32'(z));
    chk({tag, ".rd"}, 32'(out_rd), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("rst.alu_op1", alu_op1, 32'h0);
    chk("rst.out_result", out_result, 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1 chk("rel.in_ready", 32'(in_ready), 32'h1);

    run("ori", 32'h34011234, 4'd6, 32'h00001234, 1'b0, 5'd1);
    run("lui", 32'h3C02ABCD, 4'd10, 32'hABCD0000, 1'b0, 5'd2);
    chk("lui.op1", alu_op1, 32'h0000ABCD);
    run("addi", 32'h2004FFF0, 4'd3, 32'hFFFFFFF0, 1'b0, 5'd4);
    run("sra", 32'h00042883, 4'd2, 32'hFFFFFFFC, 1'b0, 5'd5);
    chk("sra.op2", alu_op2, 32'h2);
    run("sub", 32'h00211822, 4'd4, 32'h0, 1'b1, 5'd3);
    run("addi_r0", 32'h20000005, 4'd3, 32'h5, 1'b0, 5'd0);
    run("or_r0", 32'h00003025, 4'd6, 32'h0, 1'b1, 5'd6);
    run("add", 32'h00223820, 4'd3, 32'hABCD1234, 1'b0, 5'd7);
    run("slti", 32'h28880001, 4'd9, 32'h0, 1'b1, 5'd8);
    run("slt", 32'h0024482A, 4'd9, 32'h1, 1'b0, 5'd9);
    run("xori", 32'h388AFFFF, 4'd7, 32'hFFFF000F, 1'b0, 5'd10);

    @(negedge clock);
    in_valid = 1'b1;
    in_instr = 32'hFC000000;
    @(negedge clock);
    in_valid = 1'b0;
    chk("ill.err", 32'(err), 32'h1);
    chk("ill.out_valid", 32'(out_valid), 32'h0);
    chk("ill.in_ready", 32'(in_ready), 32'h1);
    chk("ill.ctrl_held", 32'(alu_ctrl), 32'h7);
    @(negedge clock);
    chk("ill.err_clear", 32'(err), 32'h0);
    chk("ill.out_valid2", 32'(out_valid), 32'h0);

    out_ready = 1'b0;
    run("bp", 32'h340B0055, 4'd6, 32'h00000055, 1'b0, 5'd11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp.valid", 32'(out_valid), 32'h1);
      chk("bp.result", out_result, 32'h00000055);
      chk("bp.rd", 32'(out_rd), 32'd11);
      chk("bp.in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    run("bp_read", 32'h01606025, 4'd6, 32'h00000055, 1'b0, 5'd12);

    @(negedge clock);
    in_valid = 1'b1;
    in_instr = 32'h34017777;
    @(negedge clock);
    in_valid = 1'b0;
    chk("abort.ctrl", 32'(alu_ctrl), 32'h6);
    reset_n = 1'b0;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'h0);
    chk("abort.out_valid", 32'(out_valid), 32'h0);
    chk("abort.alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("abort.alu_op2", alu_op2, 32'h0);
    chk("abort.out_rd", 32'(out_rd), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("abort.ready_after", 32'(in_ready), 32'h1);
    chk("abort.valid_after", 32'(out_valid), 32'h0);
    run("abort_read", 32'h00206825, 4'd6, 32'h0, 1'b1, 5'd13);

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
